loop_filter_pi_gs: RTL and testbench

Synthesizable fixed-point PI loop filter for the CFO recovery loop, with two-gear gain scheduling.
- Gains are power-of-two shifts; gears are ACQ (wide bandwidth) and TRACK (narrow).
- Includes a lock detector, integrator preload, hold and clear, and saturation with conditional-integration anti-windup.
- Sits between the phase detector and the NCO frequency input.

---
 rtl/loop_filter_pkg.sv | 34 +++
 rtl/lf_lock_detect.sv | 76 +++++++
 rtl/loop_filter_pi_gs.sv | 155 +++++++++++++++
 tb/tb_loop_filter_pi_gs.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/loop_filter_pkg.sv
// Shared types, default gear shifts and the accumulator clamp for the CFO loop filter.
package loop_filter_pkg;

    typedef enum logic {
        LF_ACQ = 1'b0,
        LF_TRK = 1'b1
    } lf_mode_e;

    localparam int LF_KP_ACQ_SHIFT = 8;
    localparam int LF_KI_ACQ_SHIFT = 14;
    localparam int LF_KP_TRK_SHIFT = 12;
    localparam int LF_KI_TRK_SHIFT = 20;

    // Wide container so one clamp serves any accumulator width up to 127 bits.
    localparam int LF_SAT_W = 128;

    function automatic logic signed [LF_SAT_W-1:0] sat_acc(
        input logic signed [LF_SAT_W-1:0] x,
        input int                         w
    );
        logic signed [LF_SAT_W-1:0] hi;
        logic signed [LF_SAT_W-1:0] lo;
        hi = (LF_SAT_W'(1) << (w - 1)) - LF_SAT_W'(1);
        lo = ~hi;
        if (x > hi) begin
            sat_acc = hi;
        end else if (x < lo) begin
            sat_acc = lo;
        end else begin
            sat_acc = x;
        end
    endfunction

endpackage

// File: rtl/lf_lock_detect.sv
// Lock detector: counts consecutive small errors to acquire lock and consecutive large errors to lose it.
module lf_lock_detect #(
    parameter int          MAG_W       = 24,
    parameter int unsigned LOCK_THRESH = 65536,
    parameter int          LOCK_CNT    = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             strobe_i,
    input  logic             track_i,
    input  logic [MAG_W-1:0] mag_i,
    output logic             locked_o,
    output logic             lol_o
);

    localparam int               CNT_W   = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_CNT);

    logic [CNT_W-1:0] small_q, small_d;
    logic [CNT_W-1:0] big_q, big_d;
    logic             locked_q, locked_d;
    logic             is_small;

    assign is_small = (32'(mag_i) < LOCK_THRESH);

    always_comb begin
        small_d  = small_q;
        big_d    = big_q;
        locked_d = locked_q;
        lol_o    = 1'b0;
        if (strobe_i && track_i) begin
            if (!locked_q) begin
                if (is_small) begin
                    small_d = (small_q == CNT_MAX) ? small_q : small_q + 1'b1;
                    if (small_d == CNT_MAX) begin
                        locked_d = 1'b1;
                        small_d  = '0;
                    end
                end else begin
                    small_d = '0;
                end
            end else begin
                if (!is_small) begin
                    big_d = (big_q == CNT_MAX) ? big_q : big_q + 1'b1;
                    if (big_d == CNT_MAX) begin
                        locked_d = 1'b0;
                        big_d    = '0;
                        lol_o    = 1'b1;
                    end
                end else begin
                    big_d = '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            small_q  <= '0;
            big_q    <= '0;
            locked_q <= 1'b0;
        end else if (clr_i) begin
            small_q  <= '0;
            big_q    <= '0;
            locked_q <= 1'b0;
        end else begin
            small_q  <= small_d;
            big_q    <= big_d;
            locked_q <= locked_d;
        end
    end

    assign locked_o = locked_q;

endmodule

// File: rtl/loop_filter_pi_gs.sv
// Two-stage PI loop filter with ACQ/TRACK gain scheduling, lock detection and anti-windup.
module loop_filter_pi_gs
    import loop_filter_pkg::*;
#(
    parameter int ERR_WIDTH    = 24,
    parameter int FREQ_WIDTH   = 32,
    parameter int ACC_WIDTH    = 48,
    parameter int KP_ACQ_SHIFT = LF_KP_ACQ_SHIFT,
    parameter int KI_ACQ_SHIFT = LF_KI_ACQ_SHIFT,
    parameter int KP_TRK_SHIFT = LF_KP_TRK_SHIFT,
    parameter int KI_TRK_SHIFT = LF_KI_TRK_SHIFT,
    parameter int ACQ_LEN      = 256,
    parameter int LOCK_THRESH  = 65536,
    parameter int LOCK_CNT     = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr_i,
    input  logic                  hold_i,
    input  logic                  load_i,
    input  logic [FREQ_WIDTH-1:0] load_val_i,
    input  logic                  err_valid_i,
    input  logic [ERR_WIDTH-1:0]  phase_err_i,
    output logic                  freq_valid_o,
    output logic [FREQ_WIDTH-1:0] freq_word_o,
    output logic                  mode_o,
    output logic                  locked_o,
    output logic                  sat_o
);

    localparam int ACQ_CW = $clog2(ACQ_LEN + 1);

    logic                        s1_valid_q;
    logic [ERR_WIDTH-1:0]        s1_err_q;
    logic [ERR_WIDTH-1:0]        s1_mag_q;
    lf_mode_e                    s1_mode_q;
    logic signed [ACC_WIDTH-1:0] integ_q;
    logic                        fv_q;
    logic [FREQ_WIDTH-1:0]       word_q;
    logic                        sat_q;
    lf_mode_e                    mode_q;
    logic [ACQ_CW-1:0]           acq_cnt_q;

    logic                        accept;
    logic                        complete;
    logic                        lol;
    logic [ERR_WIDTH-1:0]        mag_d;
    logic signed [ACC_WIDTH-1:0] e_s, prop_s, inc_s, integ_next;
    logic signed [LF_SAT_W-1:0]  raw1, sat1, raw2, sat2;
    logic                        sat_flag, aw_hold;
    logic [FREQ_WIDTH-1:0]       word_d;

    // Priority clr > load > hold > err_valid; only clr and load can kill the update in stage 1.
    assign accept   = err_valid_i && !clr_i && !load_i && !hold_i;
    assign complete = s1_valid_q && !clr_i && !load_i;

    assign mag_d = phase_err_i[ERR_WIDTH-1] ? (~phase_err_i + 1'b1) : phase_err_i;

    always_comb begin
        e_s    = {s1_err_q, {(ACC_WIDTH-ERR_WIDTH){1'b0}}};
        prop_s = (s1_mode_q == LF_ACQ) ? (e_s >>> KP_ACQ_SHIFT) : (e_s >>> KP_TRK_SHIFT);
        inc_s  = (s1_mode_q == LF_ACQ) ? (e_s >>> KI_ACQ_SHIFT) : (e_s >>> KI_TRK_SHIFT);
        raw1   = {{(LF_SAT_W-ACC_WIDTH){integ_q[ACC_WIDTH-1]}}, integ_q}
               + {{(LF_SAT_W-ACC_WIDTH){inc_s[ACC_WIDTH-1]}}, inc_s};
        sat1   = sat_acc(raw1, ACC_WIDTH);
        raw2   = sat1 + {{(LF_SAT_W-ACC_WIDTH){prop_s[ACC_WIDTH-1]}}, prop_s};
        sat2   = sat_acc(raw2, ACC_WIDTH);
        integ_next = sat1[ACC_WIDTH-1:0];
        sat_flag   = (sat2 != raw2);
        // Freeze the integrator only when its increment pushes further into the clamp.
        aw_hold    = sat_flag && ((raw2 > sat2) ? !inc_s[ACC_WIDTH-1] : inc_s[ACC_WIDTH-1]);
        word_d     = sat2[ACC_WIDTH-1 -: FREQ_WIDTH];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_err_q   <= '0;
            s1_mag_q   <= '0;
            s1_mode_q  <= LF_ACQ;
            integ_q    <= '0;
            fv_q       <= 1'b0;
            word_q     <= '0;
            sat_q      <= 1'b0;
            mode_q     <= LF_ACQ;
            acq_cnt_q  <= '0;
        end else if (clr_i) begin
            s1_valid_q <= 1'b0;
            s1_err_q   <= '0;
            s1_mag_q   <= '0;
            s1_mode_q  <= LF_ACQ;
            integ_q    <= '0;
            fv_q       <= 1'b0;
            word_q     <= '0;
            sat_q      <= 1'b0;
            mode_q     <= LF_ACQ;
            acq_cnt_q  <= '0;
        end else begin
            s1_valid_q <= accept;
            fv_q       <= complete;
            if (accept) begin
                s1_err_q  <= phase_err_i;
                s1_mag_q  <= mag_d;
                s1_mode_q <= mode_q;
            end
            if (load_i) begin
                integ_q <= {load_val_i, {(ACC_WIDTH-FREQ_WIDTH){1'b0}}};
            end else if (complete) begin
                if (!aw_hold) begin
                    integ_q <= integ_next;
                end
                word_q <= word_d;
                sat_q  <= sat_flag;
                case (mode_q)
                    LF_ACQ: begin
                        if (acq_cnt_q != ACQ_CW'(ACQ_LEN)) begin
                            acq_cnt_q <= acq_cnt_q + 1'b1;
                        end
                        if (acq_cnt_q == ACQ_CW'(ACQ_LEN - 1)) begin
                            mode_q <= LF_TRK;
                        end
                    end
                    LF_TRK: begin
                        if (lol) begin
                            mode_q    <= LF_ACQ;
                            acq_cnt_q <= '0;
                        end
                    end
                    default: mode_q <= LF_ACQ;
                endcase
            end
        end
    end

    lf_lock_detect #(
        .MAG_W      (ERR_WIDTH),
        .LOCK_THRESH(LOCK_THRESH),
        .LOCK_CNT   (LOCK_CNT)
    ) u_lock (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (clr_i),
        .strobe_i (complete),
        .track_i  (mode_q == LF_TRK),
        .mag_i    (s1_mag_q),
        .locked_o (locked_o),
        .lol_o    (lol)
    );

    assign freq_valid_o = fv_q;
    assign freq_word_o  = word_q;
    assign sat_o        = sat_q;
    assign mode_o       = mode_q;

endmodule

// File: tb/tb_loop_filter_pi_gs.sv
// Bench for loop_filter_pi_gs: randomized errors checked against an arithmetic model of the loop.
module tb_loop_filter_pi_gs;

    localparam longint ACC_MAX     = 64'sd140737488355327;
    localparam longint ACC_MIN     = -64'sd140737488355328;
    localparam int     ACQ_LEN     = 256;
    localparam int     LOCK_THRESH = 65536;
    localparam int     LOCK_CNT    = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr_i = 1'b0;
    logic        hold_i = 1'b0;
    logic        load_i = 1'b0;
    logic [31:0] load_val_i = '0;
    logic        err_valid_i = 1'b0;
    logic [23:0] phase_err_i = '0;
    logic        freq_valid_o;
    logic [31:0] freq_word_o;
    logic        mode_o;
    logic        locked_o;
    logic        sat_o;

    int checks = 0;
    int failures = 0;
    logic [32:0] exp_q[$];

    longint      m_integ;
    bit          m_mode, m_locked, m_sat;
    int          m_acq, m_small, m_big;
    logic [31:0] m_word;

    loop_filter_pi_gs dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr_i        (clr_i),
        .hold_i       (hold_i),
        .load_i       (load_i),
        .load_val_i   (load_val_i),
        .err_valid_i  (err_valid_i),
        .phase_err_i  (phase_err_i),
        .freq_valid_o (freq_valid_o),
        .freq_word_o  (freq_word_o),
        .mode_o       (mode_o),
        .locked_o     (locked_o),
        .sat_o        (sat_o)
    );

    always #5 clk = ~clk;

    function automatic longint clamp(input longint x);
        if (x > ACC_MAX) return ACC_MAX;
        if (x < ACC_MIN) return ACC_MIN;
        return x;
    endfunction

    function automatic void model_reset();
        m_integ = 0; m_mode = 1'b0; m_locked = 1'b0; m_sat = 1'b0;
        m_word = '0; m_acq = 0; m_small = 0; m_big = 0;
    endfunction

    function automatic void model_update(input int err);
        longint e, prop, inc, inext, raw, sum;
        int mag;
        e     = longint'(err) * 64'sd16777216;
        prop  = e >>> (m_mode ? 12 : 8);
        inc   = e >>> (m_mode ? 20 : 14);
        inext = clamp(m_integ + inc);
        raw   = inext + prop;
        sum   = clamp(raw);
        m_sat = (raw != sum);
        if (!(m_sat && ((raw > ACC_MAX && inc >= 0) || (raw < ACC_MIN && inc < 0))))
            m_integ = inext;
        m_word = 32'(sum >>> 16);
        mag = (err < 0) ? -err : err;
        if (!m_mode) begin
            m_acq++;
            if (m_acq == ACQ_LEN) m_mode = 1'b1;
        end else if (!m_locked) begin
            if (mag < LOCK_THRESH) begin
                m_small++;
                if (m_small == LOCK_CNT) begin m_locked = 1'b1; m_small = 0; end
            end else m_small = 0;
        end else begin
            if (mag >= LOCK_THRESH) begin
                m_big++;
                if (m_big == LOCK_CNT) begin
                    m_locked = 1'b0; m_big = 0; m_mode = 1'b0; m_acq = 0;
                end
            end else m_big = 0;
        end
    endfunction

    function automatic int rand_small();
        int v;
        v = int'($urandom_range(0, LOCK_THRESH - 1));
        return ($urandom_range(0, 1) == 1) ? -v : v;
    endfunction

    function automatic int rand_full();
        return int'($urandom_range(0, 24'hFFFFFF)) - 8388608;
    endfunction

    // Called just after a negedge; returns on the negedge where the result is visible.
    task automatic send_err(input int err, input string tag);
        err_valid_i = 1'b1;
        phase_err_i = err[23:0];
        @(negedge clk);
        err_valid_i = 1'b0;
        checks++;
        if (freq_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL %s_early: freq_valid_o=%b one cycle after accept, required 0", tag, freq_valid_o);
        end
        model_update(err);
        @(negedge clk);
        checks++;
        if (freq_valid_o !== 1'b1 || freq_word_o !== m_word || sat_o !== m_sat ||
            mode_o !== m_mode || locked_o !== m_locked) begin
            failures++;
            $display("FAIL %s: err=%0d got fv=%b word=%h sat=%b mode=%b lock=%b required fv=1 word=%h sat=%b mode=%b lock=%b",
                     tag, err, freq_valid_o, freq_word_o, sat_o, mode_o, locked_o, m_word, m_sat, m_mode, m_locked);
        end
    endtask

    task automatic check_idle_zero(input string tag);
        checks++;
        if (freq_valid_o !== 1'b0 || freq_word_o !== 32'h0 || mode_o !== 1'b0 ||
            locked_o !== 1'b0 || sat_o !== 1'b0) begin
            failures++;
            $display("FAIL %s: got fv=%b word=%h mode=%b lock=%b sat=%b required all zero",
                     tag, freq_valid_o, freq_word_o, mode_o, locked_o, sat_o);
        end
    endtask

    task automatic pulse_clr();
        clr_i = 1'b1;
        @(negedge clk);
        clr_i = 1'b0;
        model_reset();
        check_idle_zero("clr_pulse");
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_idle_zero("reset_state");
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
    endtask

    task automatic test_single();
        send_err(4194304, "single");
        checks++;
        if (freq_word_o !== 32'd4259840 || sat_o !== 1'b0 || mode_o !== 1'b0) begin
            failures++;
            $display("FAIL single_const: word=%0d sat=%b mode=%b required 4259840 0 0", freq_word_o, sat_o, mode_o);
        end
    endtask

    task automatic test_clear_inflight();
        err_valid_i = 1'b1;
        phase_err_i = 24'h123456;
        @(negedge clk);
        err_valid_i = 1'b0;
        clr_i = 1'b1;
        @(negedge clk);
        clr_i = 1'b0;
        model_reset();
        check_idle_zero("clr_inflight");
        @(negedge clk);
        check_idle_zero("clr_inflight_next");
        send_err(rand_full(), "after_clr");
    endtask

    task automatic test_back_to_back();
        logic [32:0] exp;
        int err;
        @(negedge clk);
        for (int k = 0; k <= 22; k++) begin
            checks++;
            if (k >= 2 && k <= 21) begin
                exp = exp_q.pop_front();
                if (freq_valid_o !== 1'b1 || {sat_o, freq_word_o} !== exp || mode_o !== 1'b0) begin
                    failures++;
                    $display("FAIL b2b_%0d: got fv=%b sat=%b word=%h mode=%b required fv=1 sat=%b word=%h mode=0",
                             k, freq_valid_o, sat_o, freq_word_o, mode_o, exp[32], exp[31:0]);
                end
            end else if (freq_valid_o !== 1'b0) begin
                failures++;
                $display("FAIL b2b_idle_%0d: fv=%b required 0", k, freq_valid_o);
            end
            if (k < 20) begin
                err = rand_full();
                err_valid_i = 1'b1;
                phase_err_i = err[23:0];
                model_update(err);
                exp_q.push_back({m_sat, m_word});
            end else begin
                err_valid_i = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_gear();
        pulse_clr();
        for (int i = 0; i < ACQ_LEN; i++) begin
            send_err(int'($urandom_range(0, 2097152)) - 1048576, "gear");
            if (i == ACQ_LEN - 2 || i == ACQ_LEN - 1) begin
                checks++;
                if (mode_o !== (i == ACQ_LEN - 1)) begin
                    failures++;
                    $display("FAIL gear_switch: update %0d mode_o=%b required %0b", i + 1, mode_o, i == ACQ_LEN - 1);
                end
            end
        end
    endtask

    task automatic test_lock();
        for (int i = 0; i < 63; i++) send_err(rand_small(), "lock_run1");
        send_err(70000, "lock_break");
        checks++;
        if (locked_o !== 1'b0) begin
            failures++;
            $display("FAIL lock_broken: locked_o=%b required 0", locked_o);
        end
        for (int i = 0; i < 63; i++) send_err(rand_small(), "lock_run2");
        checks++;
        if (locked_o !== 1'b0) begin
            failures++;
            $display("FAIL lock_63: locked_o=%b required 0", locked_o);
        end
        send_err(1000, "lock_64th");
        checks++;
        if (locked_o !== 1'b1) begin
            failures++;
            $display("FAIL lock_rise: locked_o=%b required 1", locked_o);
        end
    endtask

    task automatic test_hold();
        int e1;
        logic [31:0] w;
        e1 = rand_small();
        err_valid_i = 1'b1;
        phase_err_i = e1[23:0];
        @(negedge clk);
        hold_i = 1'b1;
        phase_err_i = 24'h7FFFFF;
        model_update(e1);
        @(negedge clk);
        checks++;
        if (freq_valid_o !== 1'b1 || freq_word_o !== m_word) begin
            failures++;
            $display("FAIL hold_inflight: fv=%b word=%h required fv=1 word=%h", freq_valid_o, freq_word_o, m_word);
        end
        w = m_word;
        for (int i = 0; i < 10; i++) begin
            phase_err_i = 24'(rand_full());
            @(negedge clk);
            checks++;
            if (freq_valid_o !== 1'b0 || freq_word_o !== w || mode_o !== m_mode || locked_o !== m_locked) begin
                failures++;
                $display("FAIL hold_frozen_%0d: fv=%b word=%h mode=%b lock=%b required fv=0 word=%h mode=%b lock=%b",
                         i, freq_valid_o, freq_word_o, mode_o, locked_o, w, m_mode, m_locked);
            end
        end
        hold_i = 1'b0;
        err_valid_i = 1'b0;
        @(negedge clk);
        send_err(rand_small(), "after_hold");
    endtask

    task automatic test_loss_of_lock();
        for (int i = 0; i < LOCK_CNT; i++) begin
            send_err(-8388608, "lol");
            if (i == LOCK_CNT - 2) begin
                checks++;
                if (locked_o !== 1'b1 || mode_o !== 1'b1) begin
                    failures++;
                    $display("FAIL lol_63: lock=%b mode=%b required 1 1", locked_o, mode_o);
                end
            end
        end
        checks++;
        if (locked_o !== 1'b0 || mode_o !== 1'b0) begin
            failures++;
            $display("FAIL lol_64: lock=%b mode=%b required 0 0", locked_o, mode_o);
        end
        send_err(rand_small(), "after_lol");
    endtask

    task automatic test_saturation();
        logic [31:0] w;
        w = m_word;
        err_valid_i = 1'b1;
        phase_err_i = 24'(rand_full());
        @(negedge clk);
        err_valid_i = 1'b0;
        load_i = 1'b1;
        load_val_i = 32'h7FFFFF00;
        @(negedge clk);
        load_i = 1'b0;
        m_integ = longint'($signed(load_val_i)) * 64'sd65536;
        checks++;
        if (freq_valid_o !== 1'b0 || freq_word_o !== w) begin
            failures++;
            $display("FAIL load_discard: fv=%b word=%h required fv=0 word=%h", freq_valid_o, freq_word_o, w);
        end
        @(negedge clk);
        send_err(8388607, "sat_pos");
        checks++;
        if (freq_word_o !== 32'h7FFFFFFF || sat_o !== 1'b1) begin
            failures++;
            $display("FAIL sat_const: word=%h sat=%b required 7fffffff 1", freq_word_o, sat_o);
        end
        send_err(0, "sat_readback");
        checks++;
        if (freq_word_o !== 32'h7FFFFF00 || sat_o !== 1'b0) begin
            failures++;
            $display("FAIL antiwindup: word=%h sat=%b required 7fffff00 0", freq_word_o, sat_o);
        end
        send_err(-int'($urandom_range(65536, 8388608)), "desat");
        checks++;
        if (sat_o !== 1'b0) begin
            failures++;
            $display("FAIL desat_const: sat=%b required 0", sat_o);
        end
    endtask

    task automatic test_async_reset();
        err_valid_i = 1'b1;
        phase_err_i = 24'h400000;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_zero("async_reset");
        err_valid_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        check_idle_zero("reset_release");
        send_err(rand_full(), "recover");
    endtask

    task automatic test_random();
        for (int i = 0; i < 320; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send_err(($urandom_range(0, 1) == 1) ? rand_small() : rand_full(), "random");
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_clear_inflight();
        test_back_to_back();
        test_gear();
        test_lock();
        test_hold();
        test_loss_of_lock();
        test_saturation();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
